// File: rtl/tdoa_frame_sequencer_if.sv
// Handshake and readout bundle between the frame sequencer and the
// sampler / xcorr / argmax stages plus the SPI readout path.
interface tdoa_frame_sequencer_if #(
   parameter int NUM_PAIRS  = 3,
   parameter int LAG_W      = 8,
   parameter int PEAK_W     = 32,
   parameter int FRAME_W    = 16,
   parameter int FIFO_DEPTH = 16
);
   localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   localparam int RES_W  = FRAME_W + PAIR_W + LAG_W + PEAK_W;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   logic               enable;
   logic               samp_start;
   logic               samp_done;
   logic               bank_sel;
   logic [PAIR_W-1:0]  pair_sel;
   logic               xc_start;
   logic               xc_done;
   logic               am_start;
   logic               am_done;
   logic [LAG_W-1:0]   am_lag;
   logic [PEAK_W-1:0]  am_peak;
   logic               res_rd;
   logic               res_valid;
   logic [RES_W-1:0]   res_data;
   logic [CNT_W-1:0]   res_count;
   logic               overflow;
   logic               ovf_clr;
   logic [FRAME_W-1:0] frame_cnt;
   logic               busy;

   modport master (
      input  enable, samp_done, xc_done, am_done, am_lag, am_peak, res_rd, ovf_clr,
      output samp_start, bank_sel, pair_sel, xc_start, am_start,
             res_valid, res_data, res_count, overflow, frame_cnt, busy
   );

   modport slave (
      output enable, samp_done, xc_done, am_done, am_lag, am_peak, res_rd, ovf_clr,
      input  samp_start, bank_sel, pair_sel, xc_start, am_start,
             res_valid, res_data, res_count, overflow, frame_cnt, busy
   );
endinterface

// File: rtl/tdoa_frame_sequencer.sv
// Frame sequencer: ping-pongs sample banks, runs one xcorr->argmax pass per
// mic pair on each completed frame, and queues tagged results in a FIFO.
module tdoa_frame_sequencer #(
   parameter int NUM_PAIRS  = 3,
   parameter int LAG_W      = 8,
   parameter int PEAK_W     = 32,
   parameter int FRAME_W    = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   tdoa_frame_sequencer_if.master bus
);
   localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   localparam int RES_W  = FRAME_W + PAIR_W + LAG_W + PEAK_W;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} samp_state_t;
   typedef enum logic [1:0] {P_IDLE, P_XC, P_AM}    proc_state_t;

   samp_state_t        r_samp_st;
   proc_state_t        r_proc_st;
   logic               r_bank_sel;
   logic               r_samp_start;
   logic               r_xc_start;
   logic               r_am_start;
   logic [PAIR_W-1:0]  r_pair_sel;
   logic [FRAME_W-1:0] r_frame_cnt;
   logic [FRAME_W-1:0] r_tag;

   logic [RES_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow;

   logic               w_swap;
   logic               w_launch;
   logic               w_am_acc;
   logic               w_pop;
   logic               w_full;
   logic               w_wr;
   logic               w_drop;
   logic [RES_W-1:0]   w_word;

   assign w_swap   = bus.enable && (r_samp_st != S_RUN) && (r_proc_st == P_IDLE);
   assign w_launch = w_swap && (r_samp_st == S_FULL);
   // A done coinciding with its own start pulse is too early and is dropped
   assign w_am_acc = (r_proc_st == P_AM) && bus.am_done && !r_am_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_samp_st    <= S_IDLE;
         r_proc_st    <= P_IDLE;
         r_bank_sel   <= 1'b0;
         r_samp_start <= 1'b0;
         r_xc_start   <= 1'b0;
         r_am_start   <= 1'b0;
         r_pair_sel   <= '0;
         r_frame_cnt  <= '0;
      end else begin
         r_samp_start <= 1'b0;
         r_xc_start   <= 1'b0;
         r_am_start   <= 1'b0;

         if (w_swap) begin
            r_bank_sel   <= ~r_bank_sel;
            r_samp_start <= 1'b1;
            r_samp_st    <= S_RUN;
            if (w_launch) begin
               r_pair_sel  <= '0;
               r_xc_start  <= 1'b1;
               r_proc_st   <= P_XC;
               r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
         end else if (r_samp_st == S_RUN && bus.samp_done && !r_samp_start) begin
            r_samp_st <= S_FULL;
         end

         case (r_proc_st)
            P_XC: begin
               if (bus.xc_done && !r_xc_start) begin
                  r_am_start <= 1'b1;
                  r_proc_st  <= P_AM;
               end
            end
            P_AM: begin
               if (w_am_acc) begin
                  if (r_pair_sel == LAST_PAIR) begin
                     r_proc_st <= P_IDLE;
                  end else begin
                     r_pair_sel <= r_pair_sel + PAIR_W'(1);
                     r_xc_start <= 1'b1;
                     r_proc_st  <= P_XC;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and FIFO storage are datapath; only consumed once written
   always_ff @(posedge clk) begin
      if (w_launch) r_tag <= r_frame_cnt;
   end

   assign w_word = {r_tag, r_pair_sel, bus.am_lag, bus.am_peak};
   assign w_pop  = bus.res_rd && (r_count != '0);
   assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_wr   = w_am_acc && (!w_full || w_pop);
   assign w_drop = w_am_acc && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: ;
         endcase
         // A drop wins over a simultaneous clear
         if (w_drop)           r_overflow <= 1'b1;
         else if (bus.ovf_clr) r_overflow <= 1'b0;
      end
   end

   assign bus.samp_start = r_samp_start;
   assign bus.bank_sel   = r_bank_sel;
   assign bus.pair_sel   = r_pair_sel;
   assign bus.xc_start   = r_xc_start;
   assign bus.am_start   = r_am_start;
   assign bus.res_valid  = (r_count != '0);
   assign bus.res_data   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign bus.res_count  = r_count;
   assign bus.overflow   = r_overflow;
   assign bus.frame_cnt  = r_frame_cnt;
   assign bus.busy       = (r_samp_st == S_RUN) || (r_proc_st != P_IDLE);
endmodule
